// File: rtl/bus_master_port_if.sv
// Core-side request/response and Avalon-style bus signals of the bus master port.
// The master modport is the port block's view; slave is the core + memory view.
interface bus_master_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  waitrequest, readdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output address, read, write, writedata, byteenable
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output waitrequest, readdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  address, read, write, writedata, byteenable
  );
endinterface

// File: rtl/bus_master_port.sv
// Bus master port: one byte/half/word access at a time from the core onto an
// Avalon-style bus. Misaligned/reserved-size requests and stall timeouts are
// answered with an error response and never reach the bus.
module bus_master_port #(
  parameter int TIMEOUT = 0,   // stalled cycles before abort, 0 = never
  parameter int CNT_W   = 16
) (
  input logic             clk,
  input logic             reset,
  bus_master_port_if.master bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, DONE, ERR} state_t;

  state_t      state_q, state_d;
  logic        read_q, read_d, write_q, write_d;
  logic [31:0] address_q, address_d, writedata_q, writedata_d;
  logic [3:0]  be_q, be_d;
  logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [CNT_W-1:0] stall_q, stall_d, stall_inc;
  logic [1:0]  size_q, size_d, off_q, off_d;
  logic        signed_q, signed_d;

  logic [1:0]  req_off;
  logic        req_bad;
  logic [3:0]  be_req;
  logic [31:0] wd_req;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;
  logic        timeout_hit;

  assign req_off     = bus.req_addr[1:0];
  assign stall_inc   = stall_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (stall_inc >= CNT_W'(TIMEOUT));

  // Decode incoming request: lane enables, replicated store data, alignment check
  always_comb begin
    req_bad = 1'b0;
    be_req  = 4'b0000;
    wd_req  = 32'h0;
    case (bus.req_size)
      2'b00: begin
        be_req = 4'b0001 << req_off;
        wd_req = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        req_bad = req_off[0];
        be_req  = req_off[1] ? 4'b1100 : 4'b0011;
        wd_req  = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        req_bad = (req_off != 2'b00);
        be_req  = 4'b1111;
        wd_req  = bus.req_wdata;
      end
      default: req_bad = 1'b1;
    endcase
  end

  // Extract the addressed field from readdata and sign/zero-extend it
  always_comb begin
    rd_byte = bus.readdata[{off_q, 3'b000} +: 8];
    rd_half = off_q[1] ? bus.readdata[31:16] : bus.readdata[15:0];
    case (size_q)
      2'b00:   rd_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = {{16{signed_q & rd_half[15]}}, rd_half};
      default: rd_ext = bus.readdata;
    endcase
  end

  // Next-state and next-output logic; response fields pulse for one cycle
  always_comb begin
    state_d      = state_q;
    read_d       = read_q;
    write_d      = write_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    be_d         = be_q;
    stall_d      = stall_q;
    size_d       = size_q;
    off_d        = off_q;
    signed_d     = signed_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        if (req_bad) begin
          state_d      = ERR;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          state_d     = ISSUE;
          read_d      = !bus.req_write;
          write_d     = bus.req_write;
          address_d   = {bus.req_addr[31:2], 2'b00};
          be_d        = be_req;
          writedata_d = bus.req_write ? wd_req : 32'h0;
          size_d      = bus.req_size;
          off_d       = req_off;
          signed_d    = bus.req_signed;
          stall_d     = '0;
        end
      end
      ISSUE: begin
        if (!bus.waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (write_q) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
          end else begin
            state_d = CAPTURE;
          end
        end else begin
          stall_d = stall_inc;
          if (timeout_hit) begin
            read_d       = 1'b0;
            write_d      = 1'b0;
            state_d      = ERR;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end
      CAPTURE: begin
        state_d      = DONE;
        resp_valid_d = 1'b1;
        resp_rdata_d = rd_ext;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= 32'h0;
      writedata_q  <= 32'h0;
      be_q         <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      stall_q      <= '0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      signed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      be_q         <= be_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      stall_q      <= stall_d;
      size_q       <= size_d;
      off_q        <= off_d;
      signed_q     <= signed_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE) && !reset;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.address    = address_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.writedata  = writedata_q;
  assign bus.byteenable = be_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Scoreboard bench for bus_master_port: instance 0 has no timeout, instance 1
// has TIMEOUT=2. Expected responses and bus beats are queued by the stimulus;
// a negedge monitor compares them as the DUTs present them.
module tb_bus_master_port;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; int lat; } rsp_t;
  typedef struct { logic wr; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; int ncyc; } bus_t;

  rsp_t rq[$];
  bus_t bq[$];
  int n_chk = 0, n_fail = 0, cyc = 0;

  logic        in_valid[2], in_write[2], in_signed[2];
  logic [1:0]  in_size[2];
  logic [31:0] in_addr[2], in_wdata[2];
  int          stall_cfg[2];
  logic        o_ready[2], o_rv[2], o_err[2], o_read[2], o_write[2];
  logic [31:0] o_rdata[2], o_addr[2], o_wd[2];
  logic [3:0]  o_be[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bus_master_port_if bif();
    logic [31:0] mem [16];
    logic [31:0] rdq;
    int          scnt;

    bus_master_port #(.TIMEOUT(g == 0 ? 0 : 2), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .bus(bif));

    assign bif.req_valid   = in_valid[g];
    assign bif.req_write   = in_write[g];
    assign bif.req_size    = in_size[g];
    assign bif.req_signed  = in_signed[g];
    assign bif.req_addr    = in_addr[g];
    assign bif.req_wdata   = in_wdata[g];
    assign bif.waitrequest = (bif.read || bif.write) && (scnt != 0);
    assign bif.readdata    = rdq;
    assign o_ready[g] = bif.req_ready;
    assign o_rv[g]    = bif.resp_valid;
    assign o_err[g]   = bif.resp_err;
    assign o_rdata[g] = bif.resp_rdata;
    assign o_read[g]  = bif.read;
    assign o_write[g] = bif.write;
    assign o_addr[g]  = bif.address;
    assign o_wd[g]    = bif.writedata;
    assign o_be[g]    = bif.byteenable;

    // Slave memory: stall count reloads while idle, readdata one cycle after accept
    always @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        rdq  <= 32'h0;
        scnt <= 0;
      end else begin
        if (!(bif.read || bif.write)) scnt <= stall_cfg[g];
        else if (scnt != 0) scnt <= scnt - 1;
        if (bif.write && !bif.waitrequest)
          for (int b = 0; b < 4; b++)
            if (bif.byteenable[b]) mem[bif.address[5:2]][8*b +: 8] <= bif.writedata[8*b +: 8];
        if (bif.read && !bif.waitrequest) rdq <= mem[bif.address[5:2]];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  int   acc_cyc[2] = '{0, 0};
  int   scyc[2]    = '{0, 0};
  logic prev_s[2]  = '{1'b0, 1'b0};
  rsp_t me;
  bus_t mb;
  logic ms;

  // Monitor: pop and compare responses and bus beats as the DUTs present them
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (in_valid[d] && o_ready[d]) acc_cyc[d] = cyc;
      if (o_rv[d]) begin
        if (rq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_resp dut%0d: got rdata %h err %b, none expected", d, o_rdata[d], o_err[d]);
        end else begin
          me = rq.pop_front();
          chk("resp_rdata", o_rdata[d], me.rdata);
          chk("resp_err", {31'b0, o_err[d]}, {31'b0, me.err});
          chk("resp_latency", cyc - acc_cyc[d], me.lat);
        end
      end
      ms = o_read[d] || o_write[d];
      if (ms) begin
        if (bq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_strobe dut%0d: got rd %b wr %b addr %h, no access expected", d, o_read[d], o_write[d], o_addr[d]);
        end else begin
          mb = bq[0];
          chk("bus_write", {31'b0, o_write[d]}, {31'b0, mb.wr});
          chk("bus_read", {31'b0, o_read[d]}, {31'b0, !mb.wr});
          chk("bus_address", o_addr[d], mb.addr);
          chk("bus_byteenable", {28'b0, o_be[d]}, {28'b0, mb.be});
          chk("bus_writedata", o_wd[d], mb.wd);
          scyc[d]++;
        end
      end else if (prev_s[d]) begin
        if (bq.size() != 0) begin
          mb = bq.pop_front();
          chk("strobe_cycles", scyc[d], mb.ncyc);
        end
        scyc[d] = 0;
      end
      prev_s[d] = ms;
    end
  end

  function automatic void exp_rsp(input logic [31:0] r, input logic e, input int l);
    rq.push_back('{rdata: r, err: e, lat: l});
  endfunction

  function automatic void exp_bus(input logic w, input logic [31:0] a, input logic [3:0] be,
                                  input logic [31:0] wd, input int n);
    bq.push_back('{wr: w, addr: a, be: be, wd: wd, ncyc: n});
  endfunction

  // Present one request, hold it until accepted, then scramble the fields
  task automatic req(input int d, input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd);
    bit got = 1'b0;
    @(posedge clk); #1;
    in_valid[d] = 1'b1; in_write[d] = wr; in_size[d] = sz;
    in_signed[d] = sg; in_addr[d] = a; in_wdata[d] = wd;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_ready[d]) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout dut%0d: got req_ready 0 for 20 cycles, required 1", d);
    end
    @(posedge clk); #1;
    in_valid[d] = 1'b0; in_write[d] = ~wr; in_size[d] = 2'b11;
    in_signed[d] = ~sg; in_addr[d] = ~a; in_wdata[d] = ~wd;
  endtask

  // Wait (bounded) until every queued expectation has been consumed
  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rq.size() == 0 && bq.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d resp / %0d bus pending, required 0", rq.size(), bq.size());
      rq.delete(); bq.delete();
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_write[d] = 1'b0; in_size[d] = 2'b00; in_signed[d] = 1'b0;
      in_addr[d] = 32'h0; in_wdata[d] = 32'h0; stall_cfg[d] = 0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", {31'b0, o_ready[d]}, 32'h0);
      chk("rst_strobes", {30'b0, o_read[d], o_write[d]}, 32'h0);
      chk("rst_address", o_addr[d], 32'h0);
      chk("rst_writedata", o_wd[d], 32'h0);
      chk("rst_byteenable", {28'b0, o_be[d]}, 32'h0);
      chk("rst_resp", {30'b0, o_rv[d], o_err[d]}, 32'h0);
      chk("rst_resp_rdata", o_rdata[d], 32'h0);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'b0, o_ready[0]}, 32'h1);

    // word store / load round trip
    exp_bus(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 1); exp_rsp(32'h0, 1'b0, 2);
    req(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF); drain();
    exp_bus(1'b0, 32'h10, 4'b1111, 32'h0, 1); exp_rsp(32'hDEADBEEF, 1'b0, 3);
    req(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0); drain();

    // sub-word loads from 0x80FF1234
    exp_bus(1'b1, 32'h10, 4'b1111, 32'h80FF1234, 1); exp_rsp(32'h0, 1'b0, 2);
    req(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF1234); drain();
    exp_bus(1'b0, 32'h10, 4'b1000, 32'h0, 1); exp_rsp(32'hFFFFFF80, 1'b0, 3);
    req(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0); drain();
    exp_bus(1'b0, 32'h10, 4'b1000, 32'h0, 1); exp_rsp(32'h00000080, 1'b0, 3);
    req(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0); drain();
    exp_bus(1'b0, 32'h10, 4'b1100, 32'h0, 1); exp_rsp(32'hFFFF80FF, 1'b0, 3);
    req(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0); drain();
    exp_bus(1'b0, 32'h10, 4'b0010, 32'h0, 1); exp_rsp(32'h00000012, 1'b0, 3);
    req(0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0); drain();

    // sub-word stores with lane replication
    exp_bus(1'b1, 32'h20, 4'b1100, 32'hABCDABCD, 1); exp_rsp(32'h0, 1'b0, 2);
    req(0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD); drain();
    exp_bus(1'b0, 32'h20, 4'b1111, 32'h0, 1); exp_rsp(32'hABCD0000, 1'b0, 3);
    req(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0); drain();
    exp_bus(1'b1, 32'h20, 4'b0010, 32'h5A5A5A5A, 1); exp_rsp(32'h0, 1'b0, 2);
    req(0, 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFF5A); drain();
    exp_bus(1'b0, 32'h20, 4'b1111, 32'h0, 1); exp_rsp(32'hABCD5A00, 1'b0, 3);
    req(0, 1'b0, 2'b10, 1'b1, 32'h20, 32'h0); drain();

    // rejected requests: no bus beat expected
    exp_rsp(32'h0, 1'b1, 1); req(0, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0); drain();
    exp_rsp(32'h0, 1'b1, 1); req(0, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0); drain();
    exp_rsp(32'h0, 1'b1, 1); req(0, 1'b1, 2'b01, 1'b0, 32'h21, 32'h1111); drain();

    // three waitrequest cycles on a store, then read it back
    stall_cfg[0] = 3;
    exp_bus(1'b1, 32'h30, 4'b1111, 32'h11223344, 4); exp_rsp(32'h0, 1'b0, 5);
    req(0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344); drain();
    stall_cfg[0] = 0;
    exp_bus(1'b0, 32'h30, 4'b1111, 32'h0, 1); exp_rsp(32'h11223344, 1'b0, 3);
    req(0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0); drain();

    // TIMEOUT=2 instance: abort after two stalls, then a single stall is tolerated
    stall_cfg[1] = 3;
    exp_bus(1'b1, 32'h10, 4'b1111, 32'hCAFEF00D, 2); exp_rsp(32'h0, 1'b1, 3);
    req(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D); drain();
    stall_cfg[1] = 1;
    exp_bus(1'b0, 32'h10, 4'b1111, 32'h0, 2); exp_rsp(32'h0, 1'b0, 4);
    req(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0); drain();
    stall_cfg[1] = 0;

    // reset while stalled in ISSUE: strobe drops, no response
    stall_cfg[0] = 100;
    exp_bus(1'b0, 32'h10, 4'b1111, 32'h0, 2);
    req(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    stall_cfg[0] = 0;
    @(negedge clk);
    chk("read_after_mid_reset", {31'b0, o_read[0]}, 32'h0);
    chk("ready_after_mid_reset", {31'b0, o_ready[0]}, 32'h1);
    repeat (5) @(negedge clk);
    chk("pending_beats_after_reset", bq.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test within 200000 time units");
    $fatal(1);
  end
endmodule
